// File: rtl/usb_reg_pkg.sv
// Shared definitions for the USB-side register bus initiator.
//   state_t       : frame-parser / access sequencer states
//   CMD_RNW_BIT   : bit of the CMD byte that selects read (1) or write (0)
//   FRAME_HDR_LEN : CMD, ADDR and LEN bytes that precede any data
package usb_reg_pkg;

   localparam int unsigned CMD_RNW_BIT   = 7;
   localparam int unsigned FRAME_HDR_LEN = 3;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      LEN,
      WR_DATA,
      RD_ISSUE,
      RD_WAIT,
      RD_OUT
   } state_t;

endpackage

// File: rtl/usb_reg_master.sv
// Byte-serial register bus initiator.
// Parses CMD/ADDR/LEN(/DATA) frames from the USB command stream, issues
// one-cycle reg_write / reg_read strobes to the OR-combined slaves, and
// returns read data as a valid/ready byte stream.
// Ports:
//   clk_usb, reset_n          : clock, synchronous active-low reset
//   cmd_data/valid/ready      : inbound command/data byte stream
//   rsp_data/valid/ready      : outbound read-back byte stream
//   reg_address, reg_bytecnt  : register select and byte index to slaves
//   reg_datao, reg_datai      : write data out, OR-ed slave read data in
//   reg_read, reg_write       : per-byte access strobes
//   busy                      : frame in progress
import usb_reg_pkg::*;

module usb_reg_master #(
   parameter int unsigned pBYTECNT_SIZE = 7,
   parameter int unsigned pRD_LATENCY   = 1
) (
   input  logic                     clk_usb,
   input  logic                     reset_n,
   input  logic [7:0]               cmd_data,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   output logic [7:0]               rsp_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [7:0]               reg_address,
   output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
   output logic [7:0]               reg_datao,
   input  logic [7:0]               reg_datai,
   output logic                     reg_read,
   output logic                     reg_write,
   output logic                     busy
);

   localparam int unsigned LAT_W = 2;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(pRD_LATENCY - 1);

   state_t                   state, state_n;
   logic                     rnw, rnw_n;
   logic [7:0]               count, count_n;
   logic [LAT_W-1:0]         lat, lat_n;
   logic [7:0]               reg_address_n, reg_datao_n, rsp_data_n;
   logic [pBYTECNT_SIZE-1:0] reg_bytecnt_n;
   logic                     reg_read_n, reg_write_n, rsp_valid_n;
   logic                     cmd_ready_n, busy_n;
   logic                     cmd_fire;

   assign cmd_fire = cmd_valid & cmd_ready;

   // State and registered outputs
   always_ff @(posedge clk_usb) begin
      if (!reset_n) begin
         state       <= IDLE;
         rnw         <= 1'b0;
         count       <= 8'd0;
         lat         <= '0;
         reg_address <= 8'd0;
         reg_bytecnt <= '0;
         reg_datao   <= 8'd0;
         reg_read    <= 1'b0;
         reg_write   <= 1'b0;
         rsp_data    <= 8'd0;
         rsp_valid   <= 1'b0;
         cmd_ready   <= 1'b1;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         rnw         <= rnw_n;
         count       <= count_n;
         lat         <= lat_n;
         reg_address <= reg_address_n;
         reg_bytecnt <= reg_bytecnt_n;
         reg_datao   <= reg_datao_n;
         reg_read    <= reg_read_n;
         reg_write   <= reg_write_n;
         rsp_data    <= rsp_data_n;
         rsp_valid   <= rsp_valid_n;
         cmd_ready   <= cmd_ready_n;
         busy        <= busy_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n       = state;
      rnw_n         = rnw;
      count_n       = count;
      lat_n         = lat;
      reg_address_n = reg_address;
      reg_bytecnt_n = reg_bytecnt;
      reg_datao_n   = 8'd0;
      reg_write_n   = 1'b0;
      rsp_data_n    = rsp_data;
      rsp_valid_n   = rsp_valid;
      reg_read_n    = 1'b0;
      cmd_ready_n   = 1'b0;
      busy_n        = 1'b0;

      case (state)
         IDLE: if (cmd_fire) begin
            rnw_n   = cmd_data[CMD_RNW_BIT];
            state_n = ADDR;
         end
         ADDR: if (cmd_fire) begin
            reg_address_n = cmd_data;
            state_n       = LEN;
         end
         LEN: if (cmd_fire) begin
            count_n       = cmd_data;
            reg_bytecnt_n = '0;
            if (cmd_data == 8'd0) state_n = IDLE;
            else if (rnw)         state_n = RD_ISSUE;
            else                  state_n = WR_DATA;
         end
         // count tracks bytes still to accept; the bytecnt advances once the
         // strobe for a byte has been on the bus for its cycle.
         WR_DATA: begin
            if (reg_write) reg_bytecnt_n = reg_bytecnt + pBYTECNT_SIZE'(1);
            if (cmd_fire) begin
               reg_write_n = 1'b1;
               reg_datao_n = cmd_data;
               count_n     = count - 8'd1;
            end else if (count == 8'd0) begin
               state_n = IDLE;
            end
         end
         RD_ISSUE: begin
            lat_n   = '0;
            state_n = RD_WAIT;
         end
         RD_WAIT: begin
            if (lat == LAT_LAST) begin
               rsp_data_n  = reg_datai;
               rsp_valid_n = 1'b1;
               state_n     = RD_OUT;
            end else begin
               lat_n = lat + LAT_W'(1);
            end
         end
         RD_OUT: if (rsp_valid && rsp_ready) begin
            reg_bytecnt_n = reg_bytecnt + pBYTECNT_SIZE'(1);
            count_n       = count - 8'd1;
            rsp_valid_n   = 1'b0;
            state_n       = (count == 8'd1) ? IDLE : RD_ISSUE;
         end
         default: state_n = IDLE;
      endcase

      // Strobe/ready/busy follow the state being entered so they line up with it
      reg_read_n  = (state_n == RD_ISSUE);
      cmd_ready_n = (state_n == IDLE) || (state_n == ADDR) || (state_n == LEN) ||
                    ((state_n == WR_DATA) && (count_n != 8'd0));
      busy_n      = (state_n != IDLE);
   end

endmodule

// File: tb/tb_usb_reg_master.sv
// Self-checking bench for usb_reg_master: random frames against a
// frame-level reference model and a latency-exact slave model.
import usb_reg_pkg::*;

module tb_usb_reg_master;

   localparam int unsigned BC_W   = 7;
   localparam int unsigned RD_LAT = 2;
   localparam int unsigned TMO    = 4000;

   logic            clk_usb, reset_n;
   logic [7:0]      cmd_data;
   logic            cmd_valid, cmd_ready;
   logic [7:0]      rsp_data;
   logic            rsp_valid, rsp_ready;
   logic [7:0]      reg_address, reg_datao, reg_datai;
   logic [BC_W-1:0] reg_bytecnt;
   logic            reg_read, reg_write, busy;

   usb_reg_master #(.pBYTECNT_SIZE(BC_W), .pRD_LATENCY(RD_LAT)) u_dut (
      .clk_usb(clk_usb), .reset_n(reset_n),
      .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
      .reg_datao(reg_datao), .reg_datai(reg_datai),
      .reg_read(reg_read), .reg_write(reg_write), .busy(busy)
   );

   initial begin
      clk_usb = 1'b0;
      forever #5 clk_usb = ~clk_usb;
   end

   int total, bad;
   logic [22:0] exp_wr[$], act_wr[$];   // {addr, bytecnt, data}
   logic [7:0]  exp_rsp[$], act_rsp[$];
   int n_reads, exp_reads, viol, rsp_mode;
   logic [7:0] pipe [RD_LAT+1];
   logic [7:0] none[$];

   assign reg_datai = pipe[RD_LAT];

   function automatic logic [7:0] slave_val(input logic [7:0] a, input logic [BC_W-1:0] bc);
      return (8'hA0 + {1'b0, bc}) ^ (a ^ 8'h1B);
   endfunction

   // Bus monitor, slave model (data only in the exact latency cycle) and response sink
   initial begin
      rsp_ready = 1'b0;
      for (int k = 0; k <= RD_LAT; k++) pipe[k] = 8'h00;
      forever begin
         @(negedge clk_usb);
         if (reg_write) act_wr.push_back({reg_address, reg_bytecnt, reg_datao});
         if (reg_read) n_reads++;
         if (reg_read && reg_write) viol++;
         if (!reg_write && reg_datao != 8'h00) viol++;
         if (reg_read && rsp_valid) viol++;
         for (int k = RD_LAT; k > 0; k--) pipe[k] = pipe[k-1];
         pipe[0] = reg_read ? slave_val(reg_address, reg_bytecnt) : 8'h00;
         case (rsp_mode)
            0: rsp_ready = 1'b1;
            1: rsp_ready = !rsp_ready;
            2: rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
         endcase
         if (rsp_valid && rsp_ready) act_rsp.push_back(rsp_data);
      end
   end

   task automatic clear_model();
      exp_wr.delete(); act_wr.delete(); exp_rsp.delete(); act_rsp.delete();
      n_reads = 0; exp_reads = 0;
   endtask

   // Called at a negedge; returns at the negedge after the byte transferred
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      cmd_data = b; cmd_valid = 1'b1;
      while (!cmd_ready && n < TMO) begin @(negedge clk_usb); n++; end
      if (n >= TMO) begin
         total++; bad++;
         $display("FAIL send_byte timeout got cmd_ready=%b required=1", cmd_ready);
      end
      @(negedge clk_usb);
      cmd_valid = 1'b0; cmd_data = 8'h00;
   endtask

   // Sends a frame and records what the slaves/consumer should see
   task automatic send_frame(input logic rnw, input logic [7:0] addr, input int len,
                             input logic [7:0] d[$], input int gap_max);
      logic [7:0] hdr [FRAME_HDR_LEN];
      hdr[0] = {rnw, 7'($urandom)};
      hdr[1] = addr;
      hdr[2] = 8'(len);
      for (int i = 0; i < len; i++) begin
         if (!rnw) exp_wr.push_back({addr, BC_W'(i % (1 << BC_W)), d[i]});
         else      exp_rsp.push_back(slave_val(addr, BC_W'(i % (1 << BC_W))));
      end
      if (rnw) exp_reads += len;
      for (int i = 0; i < FRAME_HDR_LEN; i++) begin
         if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk_usb);
         send_byte(hdr[i]);
      end
      if (!rnw) for (int i = 0; i < len; i++) begin
         if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk_usb);
         send_byte(d[i]);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || act_rsp.size() < exp_rsp.size()) && n < TMO) begin
         @(negedge clk_usb); n++;
      end
      repeat (4) @(negedge clk_usb);
      total++;
      if (n >= TMO) begin
         bad++;
         $display("FAIL wait_idle timeout got busy=%b required=0", busy);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00;
      repeat (3) @(negedge clk_usb);
      total++;
      if ({cmd_ready, rsp_valid, busy, reg_read, reg_write, rsp_data, reg_address, reg_bytecnt, reg_datao}
          !== {1'b1, 4'b0, 8'h00, 8'h00, 7'h00, 8'h00}) begin
         bad++;
         $display("FAIL reset_outputs got rdy=%b busy=%b addr=%h dout=%h", cmd_ready, busy, reg_address, reg_datao);
      end
      reset_n = 1'b1;
      @(negedge clk_usb);
   endtask

   task automatic test_write_basic();
      logic [7:0] d[$] = '{8'h11, 8'h22, 8'h33, 8'h44};
      clear_model(); rsp_mode = 0;
      send_frame(1'b0, 8'h1C, 4, d, 0);
      total++;
      if ({reg_write, busy} !== 2'b11) begin
         bad++; $display("FAIL last_strobe got wr,busy=%b required=11", {reg_write, busy});
      end
      @(negedge clk_usb);
      total++;
      if ({reg_write, busy} !== 2'b00) begin
         bad++; $display("FAIL busy_drop got wr,busy=%b required=00", {reg_write, busy});
      end
      wait_idle();
      total++;
      if (act_wr.size() != 4) begin
         bad++; $display("FAIL wr_basic_count got=%0d required=4", act_wr.size());
      end else foreach (exp_wr[i]) begin
         total++;
         if (act_wr[i] !== exp_wr[i]) begin
            bad++; $display("FAIL wr_basic[%0d] got=%h required=%h", i, act_wr[i], exp_wr[i]);
         end
      end
   endtask

   task automatic test_read_basic();
      clear_model(); rsp_mode = 3;
      send_frame(1'b1, 8'h1B, 4, none, 0);
      repeat (20) @(negedge clk_usb);
      total++;
      if (n_reads !== 1 || rsp_valid !== 1'b1 || rsp_data !== 8'hA0) begin
         bad++; $display("FAIL rd_stall got reads=%0d valid=%b data=%h required 1/1/a0", n_reads, rsp_valid, rsp_data);
      end
      rsp_mode = 1;
      wait_idle();
      rsp_mode = 0;
      total++;
      if (n_reads !== 4) begin
         bad++; $display("FAIL rd_basic_reads got=%0d required=4", n_reads);
      end
      total++;
      if (act_rsp.size() != 4) begin
         bad++; $display("FAIL rd_basic_count got=%0d required=4", act_rsp.size());
      end else foreach (exp_rsp[i]) begin
         total++;
         if (act_rsp[i] !== exp_rsp[i]) begin
            bad++; $display("FAIL rd_basic[%0d] got=%h required=%h", i, act_rsp[i], exp_rsp[i]);
         end
      end
   endtask

   task automatic test_len_zero();
      logic [7:0] d[$] = '{8'h77};
      clear_model(); rsp_mode = 0;
      send_frame(1'b0, 8'h33, 0, none, 0);
      send_frame(1'b1, 8'h34, 0, none, 0);
      repeat (3) @(negedge clk_usb);
      total++;
      if (act_wr.size() != 0 || n_reads != 0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
         bad++; $display("FAIL len_zero got wr=%0d rd=%0d busy=%b rdy=%b", act_wr.size(), n_reads, busy, cmd_ready);
      end
      send_frame(1'b0, 8'h35, 1, d, 0);
      send_frame(1'b1, 8'h36, 2, none, 0);
      wait_idle();
      total++;
      if (act_wr.size() != 1 || act_wr[0] !== exp_wr[0]) begin
         bad++; $display("FAIL len_zero_next_wr got n=%0d required=1 entry %h", act_wr.size(), exp_wr[0]);
      end
      total++;
      if (act_rsp.size() != 2 || act_rsp[0] !== exp_rsp[0] || act_rsp[1] !== exp_rsp[1]) begin
         bad++; $display("FAIL len_zero_next_rd got n=%0d required=2", act_rsp.size());
      end
   endtask

   task automatic test_long_write();
      logic [7:0] d[$];
      clear_model();
      for (int i = 0; i < 130; i++) d.push_back(8'($urandom));
      send_frame(1'b0, 8'h5C, 130, d, 0);
      wait_idle();
      total++;
      if (act_wr.size() != 130) begin
         bad++; $display("FAIL long_count got=%0d required=130", act_wr.size());
      end else foreach (exp_wr[i]) begin
         total++;
         if (act_wr[i] !== exp_wr[i]) begin
            bad++; $display("FAIL long[%0d] got=%h required=%h", i, act_wr[i], exp_wr[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d[$] = '{8'h5A};
      clear_model();
      exp_wr.push_back({8'h40, 7'd0, 8'hB1});
      exp_wr.push_back({8'h40, 7'd1, 8'hB2});
      send_byte(8'h00); send_byte(8'h40); send_byte(8'h04);
      send_byte(8'hB1); send_byte(8'hB2);
      reset_n = 1'b0;
      @(negedge clk_usb);
      total++;
      if ({cmd_ready, rsp_valid, busy, reg_read, reg_write, rsp_data, reg_address, reg_bytecnt, reg_datao}
          !== {1'b1, 4'b0, 8'h00, 8'h00, 7'h00, 8'h00}) begin
         bad++; $display("FAIL midreset_outputs got rdy=%b busy=%b wr=%b addr=%h", cmd_ready, busy, reg_write, reg_address);
      end
      reset_n = 1'b1;
      repeat (5) @(negedge clk_usb);
      send_frame(1'b0, 8'h01, 1, d, 0);
      wait_idle();
      total++;
      if (act_wr.size() != 3) begin
         bad++; $display("FAIL midreset_count got=%0d required=3", act_wr.size());
      end else foreach (exp_wr[i]) begin
         total++;
         if (act_wr[i] !== exp_wr[i]) begin
            bad++; $display("FAIL midreset[%0d] got=%h required=%h", i, act_wr[i], exp_wr[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_model(); rsp_mode = 2;
      for (int f = 0; f < 10; f++) begin
         logic [7:0] d[$];
         logic rnw = 1'(f % 2);
         int len = $urandom_range(0, 6);
         for (int i = 0; i < len; i++) d.push_back(8'($urandom));
         send_frame(rnw, 8'($urandom), len, d, (f < 6) ? 0 : 2);
      end
      wait_idle();
      rsp_mode = 0;
      total++;
      if (n_reads !== exp_reads) begin
         bad++; $display("FAIL b2b_reads got=%0d required=%0d", n_reads, exp_reads);
      end
      total++;
      if (act_wr.size() != exp_wr.size()) begin
         bad++; $display("FAIL b2b_wr_count got=%0d required=%0d", act_wr.size(), exp_wr.size());
      end else foreach (exp_wr[i]) begin
         total++;
         if (act_wr[i] !== exp_wr[i]) begin
            bad++; $display("FAIL b2b_wr[%0d] got=%h required=%h", i, act_wr[i], exp_wr[i]);
         end
      end
      total++;
      if (act_rsp.size() != exp_rsp.size()) begin
         bad++; $display("FAIL b2b_rd_count got=%0d required=%0d", act_rsp.size(), exp_rsp.size());
      end else foreach (exp_rsp[i]) begin
         total++;
         if (act_rsp[i] !== exp_rsp[i]) begin
            bad++; $display("FAIL b2b_rd[%0d] got=%h required=%h", i, act_rsp[i], exp_rsp[i]);
         end
      end
   endtask

   task automatic test_invariants();
      total++;
      if (viol !== 0) begin
         bad++; $display("FAIL bus_rules got violations=%0d required=0", viol);
      end
   endtask

   initial begin
      total = 0; bad = 0; viol = 0; rsp_mode = 0;
      n_reads = 0; exp_reads = 0;
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00;
      test_reset();
      test_write_basic();
      test_read_basic();
      test_len_zero();
      test_long_write();
      test_reset_mid();
      test_back_to_back();
      test_invariants();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/usb_reg_master.md
Name: usb_reg_master

Overview:
- Initiator side of the byte-serial register bus that the OpenADC-style register slaves respond to.
- Parses a command byte stream from the USB front end into register accesses. Drives address, byte count, write data, and read/write strobes.
- For reads, captures each slave's registered read data and returns it as a byte stream with valid/ready flow control.
- Sits between the USB endpoint logic and the OR-combined register slaves, all in the clk_usb domain.

Parameters:
- pBYTECNT_SIZE, 7: width of reg_bytecnt; byte index wraps modulo 2^pBYTECNT_SIZE.
- pRD_LATENCY, 1: cycles from the reg_read strobe to valid read data on reg_datai; legal range 1..3.

Ports:
- clk_usb  in  1  single clock for the whole block.
- reset_n  in  1  synchronous, active-low reset.
- cmd_data  in  8  command/data byte stream.
- cmd_valid  in  1  cmd_data valid.
- cmd_ready  out  1  block accepts cmd_data this cycle.
- rsp_data  out  8  read-back byte.
- rsp_valid  out  1  rsp_data valid.
- rsp_ready  in  1  consumer accepts rsp_data.
- reg_address  out  8  register address to slaves.
- reg_bytecnt  out  pBYTECNT_SIZE  byte index within the register.
- reg_datao  out  8  write data; connects to the slaves' reg_datai.
- reg_datai  in  8  OR of the slaves' reg_datao read data.
- reg_read  out  1  one-cycle read strobe per byte.
- reg_write  out  1  one-cycle write strobe per byte.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n=0 at a clk_usb edge):
  - State goes to IDLE.
  - All outputs are 0 except cmd_ready=1.
  - Any in-flight transaction is discarded: no further strobes, rsp_valid drops, and the pending response byte is lost.
- Frame format:
  - Byte 0 is CMD: bit7=1 read, bit7=0 write; bits[6:0] are reserved and ignored.
  - Byte 1 is ADDR.
  - Byte 2 is LEN, the number of data bytes, 0..255.
  - For writes, LEN data bytes follow.
- A byte transfers on the cmd stream when cmd_valid & cmd_ready.
- State IDLE: cmd_ready=1. On a transfer, latch rnw=cmd_data[7] and go to ADDR.
- State ADDR: cmd_ready=1. On a transfer, reg_address<=cmd_data and go to LEN.
- State LEN: cmd_ready=1. On a transfer:
  - Latch remaining count = LEN and clear reg_bytecnt to 0.
  - LEN=0 returns to IDLE with no strobes.
  - Otherwise go to WR_DATA if rnw=0, or RD_ISSUE if rnw=1.
- State WR_DATA: cmd_ready=1.
  - On each data transfer, the next cycle has reg_write=1 and reg_datao=cmd_data for exactly one cycle, using the current reg_bytecnt.
  - After that strobe cycle, reg_bytecnt increments and the count decrements.
  - Throughput is 1 byte/cycle.
  - When the last byte's strobe is issued, go to IDLE.
- State RD_ISSUE: cmd_ready=0; reg_read=1 for one cycle; go to RD_WAIT.
- State RD_WAIT: counts pRD_LATENCY cycles. On the final cycle, rsp_data<=reg_datai, rsp_valid<=1, and go to RD_OUT.
- State RD_OUT: hold rsp_data/rsp_valid until rsp_ready.
  - On the handshake, reg_bytecnt increments and the count decrements.
  - Count becomes 0: rsp_valid<=0 and go to IDLE.
  - Otherwise go to RD_ISSUE.
  - Only one read is outstanding at a time. rsp_valid deasserts the cycle after the handshake unless a new byte is loaded.
- reg_address is held stable for the whole frame and remains at its last value in IDLE.
- reg_datao is 0 whenever reg_write=0.
- reg_read and reg_write are never high in the same cycle.
- reg_bytecnt wraps from 2^pBYTECNT_SIZE-1 to 0 for long frames.
- cmd_valid gaps in WR_DATA: no strobe that cycle and state is held.
- rsp_ready held low: the state machine stalls in RD_OUT indefinitely; no extra reg_read is issued.

Decomposition:
- Shared package usb_reg_pkg:
  - state enum {IDLE, ADDR, LEN, WR_DATA, RD_ISSUE, RD_WAIT, RD_OUT}.
  - CMD_RNW_BIT=7.
  - localparam for frame header length = 3.
- No sub-module: single module with one FSM, a byte counter, and a latency counter.

Test Plan:
- Write frame {0x00,0x1C,0x04,0x11,0x22,0x33,0x44}, cmd_valid continuous -> four reg_write pulses at addr 0x1C, bytecnt 0..3, data 0x11..0x44; busy drops the cycle after the last pulse.
- Read frame {0x80,0x1B,0x04} with a slave model returning 0xA0+bytecnt one cycle after reg_read, rsp_ready toggling 1/0 -> rsp_data 0xA0,0xA1,0xA2,0xA3 in order; exactly 4 reg_read pulses, none issued while rsp_valid is pending.
- LEN=0 write and LEN=0 read -> no reg_read/reg_write; back in IDLE; next frame decodes correctly.
- Write with LEN=130, pBYTECNT_SIZE=7 -> bytecnt runs 0..127 then 0,1; 130 strobes total.
- reset_n=0 for one cycle after 2 of 4 write data bytes -> no further reg_write; all outputs 0, cmd_ready=1; a following frame {0x00,0x01,0x01,0x5A} writes 0x5A to addr 0x01.
- Back-to-back write-then-read frames with no idle gap, pRD_LATENCY=2 -> correct strobes; read data sampled 2 cycles after each reg_read.
